gcd_job_dispatcher: RTL
=======================

Name: gcd_job_dispatcher

Overview:
- Upstream front-end for the 16-bit subtractive GCD core.
- Buffers operand pairs in a small FIFO and issues them to the core one at a time.
- Handles the core's start/done protocol, captures each result, and returns it on a valid/ready result channel with operand echo and cycle count.
- Resolves zero-operand jobs locally, because the subtractive core never terminates when an operand is 0.

Parameters:
- W, 16: operand and result width; must match the core.
- DEPTH, 4: input FIFO depth; power of two, at least 2.
- CW, 16: width of the cycle counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; shared with the GCD core
- in_valid  in  1  job offered
- in_ready  out  1  FIFO not full
- in_a  in  W  operand a
- in_b  in  W  operand b
- core_start  out  1  one-cycle start pulse to the core
- core_a  out  W  operand a to the core
- core_b  out  W  operand b to the core
- core_done  in  1  core finished; high for 1 or more cycles
- core_gcd  in  W  core result; valid while core_done is high
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_a  out  W  echoed operand a
- res_b  out  W  echoed operand b
- res_gcd  out  W  gcd(a,b)
- res_cycles  out  CW  core cycles spent on the job (saturating)
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- jobs_done  out  8  completed-result count; wraps 255 to 0

Behaviour:
- Reset values:
  - State IDLE, FIFO empty, fifo_count=0, in_ready=1.
  - core_start=0, core_a=0, core_b=0.
  - res_valid=0, res_a=res_b=res_gcd=0, res_cycles=0, jobs_done=0.
- Push: occurs when in_valid and in_ready. in_ready = !full (registered occupancy, no pass-through). There is no push when full.
- Pop: only in IDLE when the FIFO is non-empty. A push and a pop in the same cycle leave fifo_count unchanged. Order is strict FIFO.
- IDLE:
  - If the FIFO is empty, stay.
  - Otherwise pop into the job registers ja/jb.
  - If ja==0 or jb==0: res_gcd = ja|jb (so (0,0) gives 0), res_cycles=0, go to OUT. No core_start is issued.
  - Otherwise go to ISSUE.
- ISSUE: core_start=1 for exactly this cycle, core_a=ja, core_b=jb. Clear the cycle counter. Go to BUSY.
- BUSY:
  - Each cycle with core_done=0, the counter increments, saturating at all-ones.
  - On core_done=1: capture core_gcd into res_gcd and go to RELEASE.
- RELEASE: wait until core_done=0 (the core holds done for up to 2 cycles), then go to OUT. This guarantees the core is back in its wait state before the next start.
- OUT:
  - res_valid=1. res_a, res_b, res_gcd and res_cycles are held stable while res_ready=0.
  - On res_ready: jobs_done increments and the block goes to IDLE.
  - IDLE may pop in the very next cycle.
- core_a/core_b hold the last job's operands outside ISSUE. The core ignores them while it is not waiting.
- Latency, zero-operand job at FIFO head in IDLE: res_valid rises 1 cycle later.
- Latency, normal job: res_valid rises 3 + BUSY-cycle count + done-high cycles after the pop.
- Reset mid-operation: the FIFO is flushed and queued jobs are lost, all outputs return to reset values, and no start is pending. The core resets on the same rst_n.
- core_done seen outside BUSY/RELEASE is ignored.

Decomposition:
- Shared package gcd_pkg:
  - GCD_W=16.
  - State enum IDLE=3'd0, ISSUE=3'd1, BUSY=3'd2, RELEASE=3'd3, OUT=3'd4.
  - Default FIFO depth constant.
- Sub-module gcd_job_fifo: synchronous FIFO of {a,b} pairs, 2W wide, DEPTH entries.
  - Ports: push, pop, full, empty, count.
  - Read data is taken from the head entry; there is no read latency.

Test Plan:
- Push (12,18) with res_ready=1 -> exactly one core_start pulse with core_a=12, core_b=18; then res_valid=1 with res_gcd=6, res_a=12, res_b=18; jobs_done=1.
- Push (7,7) -> res_gcd=7, res_cycles=1. Push (1,16) -> res_gcd=1, res_cycles=16.
- Push (0,35), then (0,0) -> no core_start ever asserted; results 35 then 0 in order; res_valid for the first one rises 1 cycle after it reaches IDLE with the FIFO non-empty.
- Hold res_ready=0 and push 6 jobs back-to-back -> job 1 is in flight, jobs 2-5 fill the FIFO (fifo_count=4), in_ready=0 blocks job 6. Release res_ready -> all 6 results appear in push order.
- Apply res_ready=0 for 10 cycles while a result is pending -> res_* stable, no core_start, jobs_done unchanged; one cycle of res_ready -> jobs_done increments.
- Assert rst_n=0 for 1 cycle during BUSY with 3 jobs queued -> next cycle res_valid=0, fifo_count=0, in_ready=1, jobs_done=0. A new job (8,12) then yields res_gcd=4.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job dispatcher and its FIFO.
package gcd_pkg;

  localparam int GCD_W          = 16;
  localparam int GCD_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    BUSY    = 3'd2,
    RELEASE = 3'd3,
    OUT     = 3'd4
  } state_e;

endpackage

// File: rtl/gcd_job_dispatcher_if.sv
// Job, core and result channels of the GCD job dispatcher.
interface gcd_job_dispatcher_if #(
  parameter int W     = gcd_pkg::GCD_W,
  parameter int DEPTH = gcd_pkg::GCD_FIFO_DEPTH,
  parameter int CW    = 16
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; the sender holds its payload stable while valid && !ready.
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            core_start;
  logic [W-1:0]    core_a;
  logic [W-1:0]    core_b;
  logic            core_done;
  logic [W-1:0]    core_gcd;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_a;
  logic [W-1:0]    res_b;
  logic [W-1:0]    res_gcd;
  logic [CW-1:0]   res_cycles;
  logic [CNTW-1:0] fifo_count;
  logic [7:0]      jobs_done;

  modport slave (
    input  in_valid, in_a, in_b, core_done, core_gcd, res_ready,
    output in_ready, core_start, core_a, core_b, res_valid,
           res_a, res_b, res_gcd, res_cycles, fifo_count, jobs_done
  );

  modport master (
    output in_valid, in_a, in_b, core_done, core_gcd, res_ready,
    input  in_ready, core_start, core_a, core_b, res_valid,
           res_a, res_b, res_gcd, res_cycles, fifo_count, jobs_done
  );

endinterface

// File: rtl/gcd_job_fifo.sv
// Synchronous FIFO of operand pairs; read data is the head entry with no latency.
module gcd_job_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage is not reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gcd_job_dispatcher.sv
// Queues GCD jobs, drives the subtractive core one job at a time, returns results.
module gcd_job_dispatcher
  import gcd_pkg::*;
#(
  parameter int W     = GCD_W,
  parameter int DEPTH = GCD_FIFO_DEPTH,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gcd_job_dispatcher_if.slave  bus,
  output state_e               state_o
);
  state_e         state_q;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic [2*W-1:0] fifo_rdata;
  logic [W-1:0]   head_a;
  logic [W-1:0]   head_b;
  logic [W-1:0]   res_a_q;
  logic [W-1:0]   res_b_q;
  logic [W-1:0]   res_gcd_q;
  logic [W-1:0]   core_a_q;
  logic [W-1:0]   core_b_q;
  logic [CW-1:0]  cycles_q;
  logic           core_start_q;
  logic           res_valid_q;
  logic [7:0]     jobs_done_q;

  assign fifo_pop         = (state_q == IDLE) && !fifo_empty;
  assign {head_a, head_b} = fifo_rdata;

  gcd_job_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.in_valid),
    .wdata_i ({bus.in_a, bus.in_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (bus.fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      res_a_q      <= '0;
      res_b_q      <= '0;
      res_gcd_q    <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      cycles_q     <= '0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      jobs_done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            res_a_q  <= head_a;
            res_b_q  <= head_b;
            cycles_q <= '0;
            // The core never terminates on a zero operand, so answer locally.
            if (head_a == '0 || head_b == '0) begin
              res_gcd_q   <= head_a | head_b;
              res_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              core_a_q     <= head_a;
              core_b_q     <= head_b;
              core_start_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          core_start_q <= 1'b0;
          cycles_q     <= '0;
          state_q      <= BUSY;
        end
        BUSY: begin
          if (bus.core_done) begin
            res_gcd_q <= bus.core_gcd;
            state_q   <= RELEASE;
          end else if (cycles_q != '1) begin
            cycles_q <= cycles_q + 1'b1;
          end
        end
        // Done may stay high a second cycle; wait it out so the next start is seen.
        RELEASE: begin
          if (!bus.core_done) begin
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            jobs_done_q <= jobs_done_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.core_start = core_start_q;
  assign bus.core_a     = core_a_q;
  assign bus.core_b     = core_b_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_a      = res_a_q;
  assign bus.res_b      = res_b_q;
  assign bus.res_gcd    = res_gcd_q;
  assign bus.res_cycles = cycles_q;
  assign bus.jobs_done  = jobs_done_q;
  assign state_o        = state_q;

endmodule
